// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: reset counter value, statistics width
// and the saturating counter step used by every predictor variant.
package bp_pkg;

  localparam int CTR_STRONG_NT = 0;
  localparam int STAT_W        = 16;
  localparam int CTR_MAX_W     = 4;

  // One saturating step of a width-bit counter held in the low bits of ctr.
  function automatic logic [CTR_MAX_W-1:0] sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   width
  );
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << width) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + 1'b1;
    else       return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One W-bit saturating up/down counter; steps only when en is high.
module sat_counter
  import bp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] ctr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ctr <= W'(CTR_STRONG_NT);
    else if (en) ctr <= W'(sat_update(CTR_MAX_W'(ctr), up, W));
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PHT of saturating counters indexed by pc XOR ghr.
// Optional statistics outputs are enabled by GSHARE_PREDICTOR_STATS_EN.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] ghr
`ifdef GSHARE_PREDICTOR_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
`endif
);

  // Handshake: valid-only, no ready. Every cycle req_valid is high a request is
  // accepted and pred_valid pulses the next cycle; every cycle upd_valid is high
  // an update is applied. Lookups see PHT and ghr as they were before the edge.

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0]  pht [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [HIST_W-1:0] ghr_nxt;

  assign idx = req_pc[IDX_W-1:0] ^ IDX_W'(ghr);

  for (genvar i = 0; i < DEPTH; i++) begin : g_pht
    sat_counter #(.W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd_valid && (upd_idx == IDX_W'(i))),
      .up    (upd_taken),
      .ctr   (pht[i])
    );
  end

  if (HIST_W == 1) begin : g_hist1
    assign ghr_nxt = upd_taken;
  end else begin : g_histn
    assign ghr_nxt = {ghr[HIST_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_idx   <= idx;
        pred_taken <= pht[idx][CTR_W-1];
      end
      if (upd_valid) ghr <= ghr_nxt;
    end
  end

`ifdef GSHARE_PREDICTOR_STATS_EN
  logic mispred;
  assign mispred = pht[upd_idx][CTR_W-1] != upd_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      if (stat_updates != '1)            stat_updates <= stat_updates + 1'b1;
      if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed, table-driven bench for gshare_predictor (default parameters).
// Statistics checks are compiled in with GSHARE_PREDICTOR_STATS_EN.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [3:0]  pred_idx;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic [3:0]  ghr;
`ifdef GSHARE_PREDICTOR_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  gshare_predictor #(.PC_W(32), .IDX_W(4), .CTR_W(2), .HIST_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .ghr        (ghr)
`ifdef GSHARE_PREDICTOR_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_mispred (stat_mispred)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        ev;
    logic        et;
    logic [3:0]  ei;
    logic [3:0]  eg;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic rv, logic [31:0] pc, logic uv, logic [3:0] ui,
                              logic ut, logic ev, logic et, logic [3:0] ei, logic [3:0] eg);
    vec_t v;
    v.rv = rv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut;
    v.ev = ev; v.et = et; v.ei = ei; v.eg = eg;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut);
    req_valid = rv;
    req_pc    = rv ? pc : $urandom;
    upd_valid = uv;
    upd_idx   = uv ? ui : 4'($urandom_range(15, 0));
    upd_taken = ut;
  endtask

  initial begin
    int valid_cycles;
    // Training at idx 3, saturation, hysteresis, hashing, collision, idle.
    vecs[0]  = mk(0, 32'h0,         1, 4'h3, 1, 0, 0, 4'h0, 4'h1);
    vecs[1]  = mk(0, 32'h0,         1, 4'h3, 1, 0, 0, 4'h0, 4'h3);
    vecs[2]  = mk(0, 32'h0,         1, 4'h3, 1, 0, 0, 4'h0, 4'h7);
    vecs[3]  = mk(0, 32'h0,         1, 4'h3, 1, 0, 0, 4'h0, 4'hF);
    vecs[4]  = mk(1, 32'hC,         0, 4'h0, 0, 1, 1, 4'h3, 4'hF);
    vecs[5]  = mk(0, 32'h0,         1, 4'h3, 0, 0, 1, 4'h3, 4'hE);
    vecs[6]  = mk(1, 32'hD,         0, 4'h0, 0, 1, 1, 4'h3, 4'hE);
    vecs[7]  = mk(0, 32'h0,         1, 4'h3, 0, 0, 1, 4'h3, 4'hC);
    vecs[8]  = mk(1, 32'hF,         0, 4'h0, 0, 1, 0, 4'h3, 4'hC);
    vecs[9]  = mk(0, 32'h0,         1, 4'h5, 1, 0, 0, 4'h3, 4'h9);
    vecs[10] = mk(0, 32'h0,         1, 4'h5, 1, 0, 0, 4'h3, 4'h3);
    vecs[11] = mk(0, 32'h0,         1, 4'h2, 1, 0, 0, 4'h3, 4'h7);
    vecs[12] = mk(1, 32'h0000_0005, 0, 4'h0, 0, 1, 0, 4'h2, 4'h7);
    vecs[13] = mk(1, 32'h0000_0005, 1, 4'h2, 1, 1, 0, 4'h2, 4'hF);
    vecs[14] = mk(1, 32'hD,         0, 4'h0, 0, 1, 1, 4'h2, 4'hF);
    vecs[15] = mk(0, 32'h0,         0, 4'h0, 0, 0, 1, 4'h2, 4'hF);
    vecs[16] = mk(1, 32'hFFFF_FFF0, 0, 4'h0, 0, 1, 0, 4'hF, 4'hF);
    vecs[17] = mk(1, 32'hABCD_EF0A, 0, 4'h0, 0, 1, 1, 4'h5, 4'hF);
    vecs[18] = mk(0, 32'h0,         1, 4'h9, 0, 0, 1, 4'h5, 4'hE);
    vecs[19] = mk(1, 32'h7,         0, 4'h0, 0, 1, 0, 4'h9, 4'hE);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    check("reset pred_valid", 32'(pred_valid), 0);
    check("reset pred_taken", 32'(pred_taken), 0);
    check("reset pred_idx", 32'(pred_idx), 0);
    check("reset ghr", 32'(ghr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      tick();
      check($sformatf("vec%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].et));
      check($sformatf("vec%0d pred_idx", i), 32'(pred_idx), 32'(vecs[i].ei));
      check($sformatf("vec%0d ghr", i), 32'(ghr), 32'(vecs[i].eg));
    end
`ifdef GSHARE_PREDICTOR_STATS_EN
    check("table stat_updates", 32'(stat_updates), 11);
    check("table stat_mispred", 32'(stat_mispred), 8);
`endif

    // Mid-run reset drops a pending prediction and clears trained state.
    drive(1, 32'h3, 0, 0, 0);
    tick();
    check("pre-reset pred_valid", 32'(pred_valid), 1);
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pred_valid", 32'(pred_valid), 0);
    check("async reset pred_taken", 32'(pred_taken), 0);
    check("async reset pred_idx", 32'(pred_idx), 0);
    check("async reset ghr", 32'(ghr), 0);
`ifdef GSHARE_PREDICTOR_STATS_EN
    check("async reset stat_updates", 32'(stat_updates), 0);
    check("async reset stat_mispred", 32'(stat_mispred), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h0000_0005, 0, 0, 0);
    tick();
    check("post-reset pred_valid", 32'(pred_valid), 1);
    check("post-reset pred_idx", 32'(pred_idx), 5);
    check("post-reset pred_taken", 32'(pred_taken), 0);

    // Three back-to-back requests then two idle cycles; ghr is 0 so idx = pc.
    valid_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        logic [3:0] lo;
        lo = (c == 0) ? 4'h2 : (c == 1) ? 4'h9 : 4'hE;
        exp_q.push_back(lo);
        drive(1, {$urandom_range(65535, 0), 12'h0, lo}, 0, 0, 0);
      end else begin
        drive(0, 0, 0, 0, 0);
      end
      tick();
      if (pred_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) check("b2b unexpected prediction", 32'(pred_idx), 32'hFFFF);
        else check($sformatf("b2b pred_idx c%0d", c), 32'(pred_idx), 32'(exp_q.pop_front()));
      end
    end
    check("b2b valid cycles", 32'(valid_cycles), 3);
    check("b2b queue drained", 32'(exp_q.size()), 0);

`ifdef GSHARE_PREDICTOR_STATS_EN
    // Fresh counters: five taken updates at idx 1 mispredict at counts 0 and 1.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int u = 0; u < 5; u++) begin
      drive(0, 0, 1, 4'h1, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("stats stat_updates", 32'(stat_updates), 5);
    check("stats stat_mispred", 32'(stat_mispred), 2);
    for (int u = 0; u < 65540; u++) begin
      drive(0, 0, 1, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("stats stat_updates saturated", 32'(stat_updates), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
